// File: rtl/halt_dump_pkg.sv
// ============================================================================
// Package      : halt_dump_pkg
// Description  : Types and constants shared between the CPU top and the
//                halted-memory dumper: FSM state encoding and the default
//                address/data widths of the 10-bit CPU data RAM.
// Revision     : 1.0  initial release
// ============================================================================
`default_nettype none

package halt_dump_pkg;

  // Address and data widths of the 10-bit CPU data RAM.
  localparam int DEFAULT_ADDR_W = 10;
  localparam int DEFAULT_DATA_W = 10;

  // Dumper FSM states. CSUM is only reachable when the checksum word is built.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    SEND = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4
  } dump_state_e;

endpackage : halt_dump_pkg

`default_nettype wire

// File: rtl/halt_mem_dumper.sv
// ============================================================================
// Module       : halt_mem_dumper
// Description  : When the CPU halt flag rises, reads a fixed window of the
//                data RAM through a second read port and streams each word
//                (with its address) on a valid/ready port. out_last marks the
//                final word; done stays high until the halt flag drops.
// Revision     : 1.0  initial release
//
// Ports:
//   clk, rst      clock (rising edge); asynchronous active-high reset
//   halted_i      CPU halted level; its rising edge starts one dump
//   mem_addr_o    RAM read address
//   mem_re_o      RAM read strobe, high while reading a word
//   mem_rdata_i   RAM read data, combinational from mem_addr_o
//   out_valid/out_ready/out_data/out_addr/out_last   word stream
//   busy          high from trigger until the final handshake
//   done          dump complete, held until halted_i falls
//
// Build option:
//   HALT_DUMP_CHECKSUM_EN  append one word carrying the modulo-2^DATA_W sum
//                          of all dumped words (out_addr = 0, out_last = 1).
// ============================================================================
`default_nettype none

module halt_mem_dumper
  import halt_dump_pkg::*;
#(
  parameter int                ADDR_W    = DEFAULT_ADDR_W,
  parameter int                DATA_W    = DEFAULT_DATA_W,
  parameter logic [ADDR_W-1:0] DUMP_BASE = '0,
  parameter int                DUMP_LEN  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halted_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_re_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  // One extra bit so DUMP_LEN-1 always fits, including DUMP_LEN = 1.
  localparam int              CNT_W    = $clog2(DUMP_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DUMP_LEN - 1);

  dump_state_e       state_q,     state_d;
  logic [ADDR_W-1:0] ptr_q,       ptr_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              halted_q,    halted_d;
  logic              armed_q,     armed_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic              out_last_q,  out_last_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
`ifdef HALT_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q,       sum_d;
`endif

  logic trigger;

  // A fresh halt edge. armed_q requires halted_i to have been seen low since
  // reset, so a reset while the CPU sits halted does not replay the dump.
  assign trigger = halted_i && !halted_q && armed_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    halted_d    = halted_i;
    armed_d     = armed_q || !halted_i;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = done_q;
`ifdef HALT_DUMP_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    case (state_q)
      IDLE: begin
        if (trigger) begin
          ptr_d   = DUMP_BASE;
          cnt_d   = '0;
          busy_d  = 1'b1;
`ifdef HALT_DUMP_CHECKSUM_EN
          sum_d   = '0;
`endif
          state_d = READ;
        end
      end

      READ: begin
        out_data_d  = mem_rdata_i;
        out_addr_d  = ptr_q;
`ifdef HALT_DUMP_CHECKSUM_EN
        out_last_d  = 1'b0;   // the checksum word closes the stream
`else
        out_last_d  = (cnt_q == LAST_CNT);
`endif
        out_valid_d = 1'b1;
        state_d     = SEND;
      end

      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
`ifdef HALT_DUMP_CHECKSUM_EN
            sum_d = sum_q + out_data_q;
            if (cnt_q == LAST_CNT) begin
              state_d = CSUM;
            end else begin
              ptr_d   = ptr_q + ADDR_W'(1);
              cnt_d   = cnt_q + CNT_W'(1);
              state_d = READ;
            end
`else
            ptr_d   = ptr_q + ADDR_W'(1);
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = READ;
`endif
          end
        end
      end

`ifdef HALT_DUMP_CHECKSUM_EN
      CSUM: begin
        out_data_d  = sum_q;
        out_addr_d  = '0;
        out_last_d  = 1'b1;
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
`endif

      DONE: begin
        if (!halted_i) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      halted_q    <= 1'b0;
      armed_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef HALT_DUMP_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      halted_q    <= halted_d;
      armed_q     <= armed_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef HALT_DUMP_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign mem_addr_o = ptr_q;
  assign mem_re_o   = (state_q == READ);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_addr   = out_addr_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule : halt_mem_dumper

`default_nettype wire

// File: tb/tb_halt_mem_dumper.sv
// ============================================================================
// Module       : tb_halt_mem_dumper
// Description  : Directed bench for halt_mem_dumper. Three instances share
//                one RAM image and the halt/ready inputs: A dumps 0..3,
//                B dumps 3FE..001 (address wrap), C dumps a single word.
// Revision     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_halt_mem_dumper;

  typedef struct packed {
    logic [9:0] addr;
    logic [9:0] data;
    logic       last;
  } word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, halted_i, out_ready;
  logic [9:0] ram [0:1023];

  logic [9:0] a_maddr, a_rdata, a_data, a_addr;
  logic       a_re, a_valid, a_last, a_busy, a_done;
  logic [9:0] b_maddr, b_rdata, b_data, b_addr;
  logic       b_re, b_valid, b_last, b_busy, b_done;
  logic [9:0] c_maddr, c_rdata, c_data, c_addr;
  logic       c_re, c_valid, c_last, c_busy, c_done;

  assign a_rdata = ram[a_maddr];
  assign b_rdata = ram[b_maddr];
  assign c_rdata = ram[c_maddr];

  halt_mem_dumper #(.ADDR_W(10), .DATA_W(10), .DUMP_BASE(10'h000), .DUMP_LEN(4)) u_a (
    .clk(clk), .rst(rst), .halted_i(halted_i),
    .mem_addr_o(a_maddr), .mem_re_o(a_re), .mem_rdata_i(a_rdata),
    .out_valid(a_valid), .out_ready(out_ready), .out_data(a_data),
    .out_addr(a_addr), .out_last(a_last), .busy(a_busy), .done(a_done));

  halt_mem_dumper #(.ADDR_W(10), .DATA_W(10), .DUMP_BASE(10'h3FE), .DUMP_LEN(4)) u_b (
    .clk(clk), .rst(rst), .halted_i(halted_i),
    .mem_addr_o(b_maddr), .mem_re_o(b_re), .mem_rdata_i(b_rdata),
    .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data),
    .out_addr(b_addr), .out_last(b_last), .busy(b_busy), .done(b_done));

  halt_mem_dumper #(.ADDR_W(10), .DATA_W(10), .DUMP_BASE(10'h002), .DUMP_LEN(1)) u_c (
    .clk(clk), .rst(rst), .halted_i(halted_i),
    .mem_addr_o(c_maddr), .mem_re_o(c_re), .mem_rdata_i(c_rdata),
    .out_valid(c_valid), .out_ready(out_ready), .out_data(c_data),
    .out_addr(c_addr), .out_last(c_last), .busy(c_busy), .done(c_done));

  // Handshake monitors.
  word_t qa[$], qb[$], qc[$];
  always @(posedge clk) begin
    if (a_valid && out_ready) qa.push_back('{a_addr, a_data, a_last});
    if (b_valid && out_ready) qb.push_back('{b_addr, b_data, b_last});
    if (c_valid && out_ready) qc.push_back('{c_addr, c_data, c_last});
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_dump(input string tag, input word_t got[$], input word_t exp[$]);
    check($sformatf("%s count", tag), got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) begin
        check($sformatf("%s[%0d] addr", tag, i), {22'd0, got[i].addr}, {22'd0, exp[i].addr});
        check($sformatf("%s[%0d] data", tag, i), {22'd0, got[i].data}, {22'd0, exp[i].data});
        check($sformatf("%s[%0d] last", tag, i), {31'd0, got[i].last}, {31'd0, exp[i].last});
      end
    end
  endtask

  function automatic word_t w(input logic [9:0] a, input logic [9:0] d, input logic l);
    return '{a, d, l};
  endfunction

  // Clocks from the trigger-accepting edge to done being visible.
`ifdef HALT_DUMP_CHECKSUM_EN
  localparam int EXP_CYC = 10;
`else
  localparam int EXP_CYC = 8;
`endif

  word_t exp_a[$], exp_b[$], exp_c[$];

  // Counts clocks until done on instance A (bounded); returns the count.
  task automatic wait_done_a(output int n);
    n = 0;
    while (!a_done && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Waits (bounded) on negedges for A to present the word at address adr.
  task automatic wait_word_a(input logic [9:0] adr, output logic found);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (a_valid && a_addr == adr) found = 1'b1;
    end
  endtask

  initial begin
    int   n;
    logic found;

    for (int i = 0; i < 1024; i++) ram[i] = 10'h000;
    ram[10'h000] = 10'h001;
    ram[10'h001] = 10'h3FF;
    ram[10'h002] = 10'h155;
    ram[10'h003] = 10'h2AA;
    ram[10'h3FE] = 10'h0AB;
    ram[10'h3FF] = 10'h0CD;

`ifdef HALT_DUMP_CHECKSUM_EN
    exp_a = '{w(10'h000, 10'h001, 1'b0), w(10'h001, 10'h3FF, 1'b0),
              w(10'h002, 10'h155, 1'b0), w(10'h003, 10'h2AA, 1'b0),
              w(10'h000, 10'h3FF, 1'b1)};
    exp_b = '{w(10'h3FE, 10'h0AB, 1'b0), w(10'h3FF, 10'h0CD, 1'b0),
              w(10'h000, 10'h001, 1'b0), w(10'h001, 10'h3FF, 1'b0),
              w(10'h000, 10'h178, 1'b1)};
    exp_c = '{w(10'h002, 10'h155, 1'b0), w(10'h000, 10'h155, 1'b1)};
`else
    exp_a = '{w(10'h000, 10'h001, 1'b0), w(10'h001, 10'h3FF, 1'b0),
              w(10'h002, 10'h155, 1'b0), w(10'h003, 10'h2AA, 1'b1)};
    exp_b = '{w(10'h3FE, 10'h0AB, 1'b0), w(10'h3FF, 10'h0CD, 1'b0),
              w(10'h000, 10'h001, 1'b0), w(10'h001, 10'h3FF, 1'b1)};
    exp_c = '{w(10'h002, 10'h155, 1'b1)};
`endif

    // ---- Reset state ----
    rst = 1'b1; halted_i = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst valid", a_valid, 1'b0);
    check("rst busy",  a_busy,  1'b0);
    check("rst done",  a_done,  1'b0);
    check("rst re",    a_re,    1'b0);
    check("rst data",  a_data,  10'h000);
    check("rst addr",  a_addr,  10'h000);
    check("rst last",  a_last,  1'b0);
    check("rst maddr", a_maddr, 10'h000);
    @(negedge clk); rst = 1'b0;

    // ---- Basic dump, wrap-around, single word, latency ----
    @(negedge clk); halted_i = 1'b1;
    @(posedge clk); #1;
    check("trig busy",  a_busy,  1'b1);
    check("trig re",    a_re,    1'b1);
    check("trig maddr", a_maddr, 10'h000);
    check("trig valid", a_valid, 1'b0);
    @(posedge clk); #1;
    check("first valid", a_valid, 1'b1);
    check("first data",  a_data,  10'h001);
    check("wrap first addr", b_addr, 10'h3FE);
    wait_done_a(n);
    n = n + 1;
    check("basic done cycles", n, EXP_CYC);
    check("basic busy after", a_busy, 1'b0);
    check_dump("basic", qa, exp_a);
    check_dump("wrap",  qb, exp_b);
    check_dump("len1",  qc, exp_c);

    // ---- Re-arm ----
    @(negedge clk); halted_i = 1'b0;
    @(posedge clk); #1;
    check("rearm done clear", a_done, 1'b0);
    qa.delete();

    // ---- Second dump with backpressure on word 2 ----
    @(negedge clk); halted_i = 1'b1;
    wait_word_a(10'h001, found);
    check("bp reach word2", found, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp valid", a_valid, 1'b1);
      check("bp data",  a_data,  10'h3FF);
      check("bp addr",  a_addr,  10'h001);
      check("bp count", qa.size(), 1);
      // halt flag falling and rising mid-dump must both be ignored
      if (i == 1) halted_i = 1'b0;
      if (i == 2) halted_i = 1'b1;
    end
    @(negedge clk); out_ready = 1'b1;
    wait_done_a(n);
    check("bp done", a_done, 1'b1);
    check_dump("rearm", qa, exp_a);

    // ---- Reset mid-dump ----
    @(negedge clk); halted_i = 1'b0;
    @(negedge clk); qa.delete(); halted_i = 1'b1;
    wait_word_a(10'h001, found);
    check("mid reach word2", found, 1'b1);
    rst = 1'b1;
    #1;
    check("mid rst valid", a_valid, 1'b0);
    check("mid rst busy",  a_busy,  1'b0);
    check("mid rst data",  a_data,  10'h000);
    check("mid rst addr",  a_addr,  10'h000);
    check("mid rst re",    a_re,    1'b0);
    check("mid rst count", qa.size(), 1);
    @(negedge clk); rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("no redump busy",  a_busy,  1'b0);
    check("no redump count", qa.size(), 1);
    @(negedge clk); halted_i = 1'b0; qa.delete();
    @(negedge clk); halted_i = 1'b1;
    wait_done_a(n);
    check("restart done", a_done, 1'b1);
    check_dump("restart", qa, exp_a);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule : tb_halt_mem_dumper

`default_nettype wire
